// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue
//
// Buffers retiring results in front of the register file write port and
// keeps a per-register count of writes still in flight so that decode can
// detect RAW hazards.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   result handshake from the EX/MEM path
//   in_addr, in_data      destination register and result value
//   wr_stall              register file port busy; hold the head entry
//   wr_en, write_addr,    register file write port (one write per cycle)
//   w_data
//   iss_valid / iss_ready decode records an instruction that writes iss_addr
//   iss_addr              destination of the issued instruction
//   chk_addr1, chk_addr2  source registers to check
//   busy1, busy2          source register has a write still pending
//
// Parameters
//   n      data width of results and w_data
//   DEPTH  queue entries (power of 2, >= 2)
//   CNT_W  width of each pending counter (saturates at 2^CNT_W-1)
//
// Optional feature (macro RF_WB_BYPASS_EN)
//   When defined, a result arriving at an empty, unstalled queue is written
//   to the register file in the same cycle instead of being stored.
//   When undefined, every result goes through the queue and the write port
//   is driven purely from registered state.
// ---------------------------------------------------------------------------
module rf_writeback_queue #(
    parameter int n     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_addr,
    input  logic [n-1:0] in_data,

    input  logic         wr_stall,
    output logic         wr_en,
    output logic [4:0]   write_addr,
    output logic [n-1:0] w_data,

    input  logic         iss_valid,
    output logic         iss_ready,
    input  logic [4:0]   iss_addr,

    input  logic [4:0]   chk_addr1,
    input  logic [4:0]   chk_addr2,
    output logic         busy1,
    output logic         busy2
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -----------------------------------------------------------------------
    // Queue storage and pointers
    // -----------------------------------------------------------------------
    logic [4:0]       addr_mem [DEPTH];
    logic [n-1:0]     data_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    // Pending-write counters, one per architectural register.
    logic [CNT_W-1:0] cnt [32];

    logic        empty;
    logic        full;
    logic        bypass;
    logic        push_hs;
    logic        store;
    logic        q_pop;
    logic        rf_pop;
    logic        iss_fire;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef RF_WB_BYPASS_EN
    // A result that finds the queue empty and the port free skips storage.
    assign bypass = empty & in_valid & (in_addr != 5'd0) & ~wr_stall;
`else
    assign bypass = 1'b0;
`endif

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready = ~full | ~wr_stall;
    assign push_hs  = in_valid & in_ready;

    // Writes to r0 complete the handshake but are dropped: they have no
    // architectural effect and must never reach the register file.
    assign store = push_hs & (in_addr != 5'd0) & ~bypass;
    assign q_pop = ~empty & ~wr_stall;

    // -----------------------------------------------------------------------
    // Register file write port
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        wr_en      = 1'b0;
        write_addr = '0;
        w_data     = '0;
        if (!empty) begin
            wr_en      = 1'b1;
            write_addr = addr_mem[rd_ptr];
            w_data     = data_mem[rd_ptr];
        end else if (bypass) begin
            wr_en      = 1'b1;
            write_addr = in_addr;
            w_data     = in_data;
        end
    end

    // A write leaves the port (and retires its pending count) this cycle.
    assign rf_pop = wr_en & ~wr_stall;

    // -----------------------------------------------------------------------
    // Queue state
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({store, q_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage is not reset; an entry is only ever read after
    // it has been written, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    // An issue may be recorded when the counter has headroom, or when a
    // retiring write of the same register frees a slot in the same cycle.
    assign iss_ready = (cnt[iss_addr] != CNT_MAX) | dec_vec[iss_addr];
    assign iss_fire  = iss_valid & iss_ready & (iss_addr != 5'd0);

    assign inc_vec = iss_fire ? (32'd1 << iss_addr)   : 32'd0;
    assign dec_vec = rf_pop   ? (32'd1 << write_addr) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    // Retiring a write that was never issued holds at zero.
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // A bypass write retires in the cycle it arrives, so the last pending
    // count for that register is already gone from decode's point of view.
    assign busy1 = (chk_addr1 != 5'd0) & (cnt[chk_addr1] != '0) &
                   ~(bypass & (in_addr == chk_addr1) & (cnt[chk_addr1] == CNT_ONE));
    assign busy2 = (chk_addr2 != 5'd0) & (cnt[chk_addr2] != '0) &
                   ~(bypass & (in_addr == chk_addr2) & (cnt[chk_addr2] == CNT_ONE));

endmodule
